// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory access controller.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF = 10;

  // req_ctrl encodings
  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  // Access size field (req_ctrl[1:0])
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  function automatic logic ctrl_legal(input logic [2:0] c);
    return (c == CTRL_B) || (c == CTRL_H) || (c == CTRL_W) ||
           (c == CTRL_BU) || (c == CTRL_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte/half lane handling: load extract+extend and store merge.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  ctrl_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0] byte_sh;
  logic [4:0] half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the addressed lane, extend it for loads and splice it for stores
  always_comb begin
    byte_sh = {lane_i, 3'b000};
    half_sh = {lane_i[1], 4'b0000};
    byte_v  = 8'(word_i >> byte_sh);
    half_v  = 16'(word_i >> half_sh);
    load_o  = word_i;
    merge_o = word_i;
    case (ctrl_i[1:0])
      SZ_BYTE: begin
        load_o  = ctrl_i[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
        merge_o = (word_i & ~(32'h0000_00FF << byte_sh)) |
                  ({24'b0, wdata_i[7:0]} << byte_sh);
      end
      SZ_HALF: begin
        load_o  = ctrl_i[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
        merge_o = (word_i & ~(32'h0000_FFFF << half_sh)) |
                  ({16'b0, wdata_i} << half_sh);
      end
      default: begin
        load_o  = word_i;
        merge_o = word_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: byte/half/word loads and stores over a
// word-wide synchronous memory, sub-word stores done as read-modify-write.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned AB = ADDR_W + 2;

  state_t        state_q, state_d;
  logic [AB-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          req_err;
  logic [31:0]   load_word;
  logic [31:0]   merge_word;

  dmem_lane_align u_lane (
    .word_i  (mem_rdata),
    .lane_i  (addr_q[1:0]),
    .ctrl_i  (ctrl_q),
    .wdata_i (wdata_q),
    .load_o  (load_word),
    .merge_o (merge_word)
  );

  // Legality of the presented request: encoding, alignment, address range
  always_comb begin
    req_err = !ctrl_legal(req_ctrl);
    if ((req_ctrl[1:0] == SZ_HALF) && req_addr[0]) req_err = 1'b1;
    if ((req_ctrl[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if ((req_addr >> AB) != 32'd0) req_err = 1'b1;
  end

  // Next state, captured request fields and memory command
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    ctrl_d     = ctrl_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        // rst gating keeps the memory quiet if req_valid is high during reset
        if (req_valid && !rst) begin
          addr_d  = req_addr[AB-1:0];
          wdata_d = req_wdata[15:0];
          we_d    = req_we;
          ctrl_d  = req_ctrl;
          err_d   = req_err;
          rdata_d = '0;
          if (req_err) begin
            state_d = RESP;
          end else if (req_we && (req_ctrl == CTRL_W)) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = req_addr[AB-1:2];
            mem_wdata = req_wdata;
            state_d   = RESP;
          end else begin
            mem_en   = 1'b1;
            mem_addr = req_addr[AB-1:2];
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (we_q) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q[AB-1:2];
          mem_wdata = merge_word;
        end else begin
          rdata_d = load_word;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request/response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes expected responses from a
// word-array reference model; a monitor pops and compares on each response.
module tb_dmem_ctrl;

  localparam int AW = 10;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_we = 1'b0;
  logic [2:0]    req_ctrl = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  dmem_ctrl #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_ctrl   (req_ctrl),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Attached memory: synchronous, one-cycle read latency
  logic [31:0] ram [NW];
  logic        mem_init = 1'b1;
  int          mem_en_cnt = 0;
  int          we_cnt = 0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NW; i++) ram[i] <= pat(i);
    end else if (mem_en) begin
      mem_en_cnt <= mem_en_cnt + 1;
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        we_cnt <= we_cnt + 1;
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: memory as a plain word array
  logic [31:0] ref_mem [NW];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned acc;
    int          en_base;
    int          en_exp;
  } sb_entry_t;
  sb_entry_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic [2:0] c, output logic [31:0] rd, output logic err,
                       output int unsigned lat, output int en);
    int unsigned idx, sh;
    logic [31:0] w, v;
    err = (c == 3'd3) || (c == 3'd6) || (c == 3'd7) ||
          (c[1:0] == 2'd1 && a[0]) || (c[1:0] == 2'd2 && a[1:0] != 2'd0) ||
          (a >= 32'(4 * NW));
    rd = '0; lat = 2; en = 0;
    if (err) begin
      lat = 1;
      return;
    end
    idx = (a / 4) % NW;
    sh  = (a % 4) * 8;
    w   = ref_mem[idx];
    if (!we) begin
      en = 1;
      case (c[1:0])
        2'd0: begin
          v = (w >> sh) & 32'hFF;
          if (!c[2] && v[7]) v = v | 32'hFFFF_FF00;
        end
        2'd1: begin
          v = (w >> sh) & 32'hFFFF;
          if (!c[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        default: v = w;
      endcase
      rd = v;
    end else begin
      case (c[1:0])
        2'd2: begin ref_mem[idx] = wd; lat = 1; en = 1; end
        2'd0: begin ref_mem[idx] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh); en = 2; end
        default: begin ref_mem[idx] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh); en = 2; end
      endcase
    end
  endtask

  // Drive a request from posedge+1; returns the acceptance cycle
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic [2:0] c, output int unsigned acc);
    sb_entry_t e;
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_we = we; req_ctrl = c;
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cycle;
        model(a, wd, we, c, e.rdata, e.err, e.lat, e.en_exp);
        e.acc = cycle;
        e.en_base = mem_en_cnt;
        sb.push_back(e);
        if (e.err) begin
          chk("cmd_en_on_err", 32'(mem_en), 32'd0);
        end else begin
          chk("cmd_en", 32'(mem_en), 32'd1);
          chk("cmd_we", 32'(mem_we), 32'(we && c[1:0] == 2'd2));
          chk("cmd_addr", 32'(mem_addr), (a / 4) % NW);
          if (we && c[1:0] == 2'd2) chk("cmd_wdata", mem_wdata, wd);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++; n_fail++;
    $display("FAIL req_timeout: got no acceptance expected acceptance within 100 cycles");
    req_valid = 1'b0;
  endtask

  // Monitor: pop and compare on each response, check hold stability
  bit          in_resp = 1'b0;
  sb_entry_t   cur;
  logic [31:0] held_rd;
  logic        held_err;
  always @(negedge clk) begin
    if (rst) begin
      in_resp = 1'b0;
    end else begin
      chk("we_without_en", 32'(mem_we && !mem_en), 32'd0);
      if (resp_valid) begin
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (!in_resp) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
          end else begin
            cur = sb.pop_front();
            chk("latency", cycle - cur.acc, cur.lat);
            chk("rdata", resp_rdata, cur.rdata);
            chk("err", 32'(resp_err), 32'(cur.err));
            chk("mem_en_pulses", 32'(mem_en_cnt - cur.en_base), 32'(cur.en_exp));
          end
          in_resp  = 1'b1;
          held_rd  = resp_rdata;
          held_err = resp_err;
        end else begin
          chk("hold_rdata", resp_rdata, held_rd);
          chk("hold_err", 32'(resp_err), 32'(held_err));
        end
        if (resp_ready) in_resp = 1'b0;
      end
    end
  end

  bit rr_random = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rr_random) resp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !in_resp && !resp_valid) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL idle_timeout: got %0d pending expected 0", sb.size());
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int unsigned acc, r;
    int          base_we;
    bit          seen;
    logic [31:0] a, wd;

    for (int i = 0; i < NW; i++) ref_mem[i] = pat(i);

    // Reset state
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    mem_init = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    resp_ready = 1'b1;

    // Directed accesses
    do_req(32'h10, 32'hDEAD_BEEF, 1'b1, 3'b010, acc);
    do_req(32'h10, 32'h0,         1'b0, 3'b010, acc);
    do_req(32'h10, 32'h1122_3344, 1'b1, 3'b010, acc);
    do_req(32'h13, 32'h0,         1'b0, 3'b000, acc);
    do_req(32'h10, 32'h80FF_0000, 1'b1, 3'b010, acc);
    do_req(32'h12, 32'h0,         1'b0, 3'b001, acc);
    do_req(32'h12, 32'h0,         1'b0, 3'b101, acc);
    do_req(32'h10, 32'hAABB_CCDD, 1'b1, 3'b010, acc);
    do_req(32'h11, 32'h0000_0055, 1'b1, 3'b000, acc);
    do_req(32'h10, 32'h0,         1'b0, 3'b010, acc);
    do_req(32'h1E, 32'h1234_ABCD, 1'b1, 3'b001, acc);
    do_req(32'h1C, 32'h0,         1'b0, 3'b010, acc);
    // Rejected accesses
    do_req(32'h11,   32'h0,  1'b0, 3'b001, acc);
    do_req(32'h12,   32'h77, 1'b1, 3'b010, acc);
    do_req(32'h10,   32'h0,  1'b0, 3'b111, acc);
    do_req(32'h1000, 32'h0,  1'b0, 3'b010, acc);

    // Response held off, then back-to-back request
    wait_idle();
    resp_ready = 1'b0;
    do_req(32'h10, 32'h0, 1'b0, 3'b010, acc);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("hold_resp_seen", 32'(seen), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    resp_ready = 1'b1;
    r = cycle;
    do_req(32'h14, 32'h0, 1'b0, 3'b100, acc);
    chk("b2b_accept_cycle", acc, r + 1);

    // Reset during RD_WAIT of a byte store
    wait_idle();
    base_we = we_cnt;
    req_valid = 1'b1; req_addr = 32'h11; req_wdata = 32'h77; req_we = 1'b1; req_ctrl = 3'b000;
    @(negedge clk);
    chk("abort_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      chk("abort_mem_en", 32'(mem_en), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    chk("abort_no_write", 32'(we_cnt - base_we), 32'd0);
    @(posedge clk); #1;
    do_req(32'h10, 32'h0, 1'b0, 3'b010, acc);

    // Randomized traffic over a small window plus occasional out-of-range
    rr_random = 1'b1;
    repeat (400) begin
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 63));
      wd = $urandom;
      do_req(a, wd, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), acc);
    end
    wait_idle();
    rr_random = 1'b0;

    // Final memory image
    for (int i = 0; i < NW; i++) chk("mem_image", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10, meaning the word-address width of the attached data memory (1024 words).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port req_valid, input, 1 bit: the requester presents an access.
REQ-005 The module SHALL have port req_ready, output, 1 bit: the controller accepts the access this cycle.
REQ-006 The module SHALL have port req_addr, input, 32 bits: byte address.
REQ-007 The module SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-008 The module SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 The module SHALL have port req_ctrl, input, 3 bits: access type; 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-010 The module SHALL have ports resp_valid (output, 1 bit) and resp_ready (input, 1 bit): the response handshake.
REQ-011 The module SHALL have port resp_rdata, output, 32 bits: load result, sign- or zero-extended.
REQ-012 The module SHALL have port resp_err, output, 1 bit: the access was rejected.
REQ-013 The module SHALL have ports mem_en (output, 1 bit), mem_we (output, 1 bit) and mem_addr (output, ADDR_W bits, word index): the memory command.
REQ-014 The module SHALL have ports mem_wdata (output, 32 bits) and mem_rdata (input, 32 bits): memory data; read data is valid the cycle after mem_en=1 with mem_we=0.

Function
REQ-015 The FSM SHALL have states IDLE, RD_WAIT and RESP, and req_ready SHALL be 1 only in IDLE.
REQ-016 An access is accepted in cycle N when req_valid and req_ready are both 1; all request fields SHALL be registered at acceptance.
REQ-017 On acceptance, the access SHALL be rejected (resp_err=1, no memory command, next state RESP) if any of these holds: req_ctrl is 011, 110 or 111; a half access has req_addr[0]=1; a word access has req_addr[1:0]!=0; req_addr[31:ADDR_W+2] is non-zero.
REQ-018 A legal word store SHALL drive mem_en=1, mem_we=1, mem_addr=req_addr[ADDR_W+1:2] and mem_wdata=req_wdata in cycle N, then go to RESP; resp_valid SHALL be 1 in cycle N+1.
REQ-019 A legal load or byte/half store SHALL issue a read (mem_en=1, mem_we=0) in cycle N and go to RD_WAIT.
REQ-020 In RD_WAIT, a load SHALL extract lane addr[1:0] (byte) or addr[1] (half) from mem_rdata, extend it by req_ctrl[2] (0 = sign, 1 = zero), register it into resp_rdata and go to RESP; resp_valid SHALL be 1 in cycle N+2.
REQ-021 In RD_WAIT, a sub-word store SHALL write mem_rdata with only the addressed byte or half replaced by req_wdata[7:0] or req_wdata[15:0] (mem_en=1, mem_we=1, same mem_addr), then go to RESP.
REQ-022 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until resp_ready=1, after which the FSM SHALL return to IDLE; no new request is accepted in that same cycle.
REQ-023 resp_rdata SHALL be 0 for stores and for rejected accesses.
REQ-024 mem_en SHALL be 0 in every cycle not listed in REQ-018 to REQ-021, and mem_we SHALL never be 1 unless mem_en is 1.

Reset
REQ-025 While rst=1, the state SHALL be IDLE and the outputs SHALL be: req_ready=1 (after reset release), resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-026 Reset asserted in RD_WAIT or RESP SHALL abort the access, with no memory write and no response issued afterwards.

Structure
REQ-027 Package dmem_pkg SHALL hold the req_ctrl encodings as named constants, the FSM state enum and ADDR_W's default.
REQ-028 Lane extract/extend and merge logic SHALL be a combinational sub-module named dmem_lane_align.

Verification
REQ-029 Store word 0xDEADBEEF at 0x10, resp_ready=1 -> mem_we at N with mem_addr=4; resp_valid at N+1, err=0; a word load at 0x10 returns 0xDEADBEEF at N+2.
REQ-030 With memory word 4 = 0x11223344, a signed byte load at 0x13 -> resp_rdata=0x00000011; with word 4 = 0x80FF0000, a signed half load at 0x12 -> 0xFFFF80FF and an unsigned half load at 0x12 -> 0x000080FF.
REQ-031 With word 4 = 0xAABBCCDD, a byte store of 0x55 at 0x11 -> word 4 = 0xAABB55DD; response at N+2.
REQ-032 Half load at 0x11, word store at 0x12, ctrl=111, and addr=0x00001000 with ADDR_W=10 -> each gives resp_err=1 and resp_rdata=0, with no mem_en pulse.
REQ-033 resp_ready held at 0 for 5 cycles in RESP -> resp_valid/rdata stable and req_ready=0 throughout; when ready rises, IDLE follows and a back-to-back request is accepted the next cycle.
REQ-034 rst pulsed during RD_WAIT of a byte store -> no mem_we asserted, resp_valid=0, and the target word is unchanged.
